// File: rtl/axis_stream_sink_if.sv
// Stream-side and consumer-side signal bundle for axis_stream_sink.
// The slave modport is the sink's view; master is the producer/consumer view.
interface axis_stream_sink_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    logic [DATA_W-1:0]      i_tdata;
    logic                   i_tvalid;
    logic                   i_tlast;
    logic                   o_tready;
    logic [DATA_W-1:0]      o_rd_data;
    logic                   o_rd_last;
    logic                   o_rd_valid;
    logic                   i_rd_en;
    logic [$clog2(DEPTH):0] o_level;
    logic [7:0]             o_pkt_cnt;
    logic                   o_in_pkt;

    modport slave (
        input  i_tdata, i_tvalid, i_tlast, i_rd_en,
        output o_tready, o_rd_data, o_rd_last, o_rd_valid, o_level, o_pkt_cnt, o_in_pkt
    );

    modport master (
        output i_tdata, i_tvalid, i_tlast, i_rd_en,
        input  o_tready, o_rd_data, o_rd_last, o_rd_valid, o_level, o_pkt_cnt, o_in_pkt
    );
endinterface

// File: rtl/axis_stream_sink.sv
// AXI4-Stream sink: show-ahead FIFO of {tlast, tdata} with occupancy,
// packet counter and an in-packet tracker.
module axis_stream_sink #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    axis_stream_sink_if.slave s
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

    state_t          state;
    logic [DATA_W:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     level, level_nxt;
    logic [7:0]      pkt_cnt;
    logic            tready;
    logic            accept, pop;

    assign accept = s.i_tvalid & tready;
    assign pop    = s.i_rd_en & (level != '0);

    always_comb begin
        level_nxt = level;
        if (accept && !pop)
            level_nxt = level + (AW+1)'(1);
        else if (pop && !accept)
            level_nxt = level - (AW+1)'(1);
    end

    // tready is registered from the post-edge level, so a pop while full
    // only reopens the input on the following cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            pkt_cnt <= '0;
            tready  <= 1'b0;
            state   <= IDLE;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            level  <= level_nxt;
            tready <= (level_nxt != FULL);
            if (accept) begin
                mem[wr_ptr] <= {s.i_tlast, s.i_tdata};
                wr_ptr      <= wr_ptr + AW'(1);
                if (s.i_tlast)
                    pkt_cnt <= pkt_cnt + 8'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case (state)
                IDLE:   if (accept && !s.i_tlast) state <= IN_PKT;
                IN_PKT: if (accept &&  s.i_tlast) state <= IDLE;
            endcase
        end
    end

    assign s.o_tready                = tready;
    assign s.o_rd_valid              = (level != '0);
    assign {s.o_rd_last, s.o_rd_data} = mem[rd_ptr];
    assign s.o_level                 = level;
    assign s.o_pkt_cnt               = pkt_cnt;
    assign s.o_in_pkt                = (state == IN_PKT);
endmodule

// File: tb/tb_axis_stream_sink.sv
// Bench for axis_stream_sink: queue-based reference model, scoreboard of
// accepted beats, negedge monitor, directed scenarios then random traffic.
module tb_axis_stream_sink;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    axis_stream_sink_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    axis_stream_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .s     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [DATA_W:0] exp_q [$];
    int              m_level = 0;
    bit              m_ready = 0;
    bit              m_inpkt = 0;
    int              m_pkt   = 0;
    bit              m_acc, m_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_level = 0;
        m_ready = 0;
        m_inpkt = 0;
        m_pkt   = 0;
    endtask

    // model: FIFO as a queue, ready follows post-edge occupancy
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            m_acc = bus.i_tvalid && m_ready;
            m_pop = bus.i_rd_en && (m_level > 0);
            if (m_acc) begin
                exp_q.push_back({bus.i_tlast, bus.i_tdata});
                if (bus.i_tlast) m_pkt = (m_pkt + 1) % 256;
                m_inpkt = !bus.i_tlast;
            end
            m_level = m_level + int'(m_acc) - int'(m_pop);
            m_ready = (m_level != DEPTH);
        end
    end

    // monitor: compare status every cycle, check popped beats against scoreboard
    initial forever begin
        logic [DATA_W:0] e;
        @(negedge clk);
        chk("tready",   bus.o_tready,   m_ready);
        chk("level",    bus.o_level,    m_level);
        chk("rd_valid", bus.o_rd_valid, m_level != 0);
        chk("pkt_cnt",  bus.o_pkt_cnt,  m_pkt);
        chk("in_pkt",   bus.o_in_pkt,   m_inpkt);
        if (rst_n && bus.i_rd_en && m_level > 0) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL scoreboard_empty: got pop expected no pop at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", bus.o_rd_data, e[DATA_W-1:0]);
                chk("rd_last", bus.o_rd_last, e[DATA_W]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic l);
        bit done = 0;
        bus.i_tdata  = d;
        bus.i_tlast  = l;
        bus.i_tvalid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            done = m_ready;
            step();
        end
        bus.i_tvalid = 1'b0;
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got no accept expected accept at %0t", $time);
        end
    endtask

    task automatic drain();
        bus.i_rd_en = 1'b1;
        for (int k = 0; k < 50 && m_level > 0; k++) step();
        bus.i_rd_en = 1'b0;
        chk("drain_level", bus.o_level, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tready"},   bus.o_tready,   0);
        chk({tag, "_rd_valid"}, bus.o_rd_valid, 0);
        chk({tag, "_rd_data"},  bus.o_rd_data,  0);
        chk({tag, "_rd_last"},  bus.o_rd_last,  0);
        chk({tag, "_in_pkt"},   bus.o_in_pkt,   0);
        chk({tag, "_level"},    bus.o_level,    0);
        chk({tag, "_pkt_cnt"},  bus.o_pkt_cnt,  0);
    endtask

    initial begin
        bus.i_tdata  = '0;
        bus.i_tvalid = 1'b0;
        bus.i_tlast  = 1'b0;
        bus.i_rd_en  = 1'b0;
        #1;
        check_all_zero("rst");

        // release between edges; ready rises on the first edge after
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("tready_pre_edge", bus.o_tready, 0);
        step();
        chk("tready_post_rst", bus.o_tready, 1);

        // two-beat packet then two pops
        send(8'h56, 1'b0);
        send(8'h89, 1'b1);
        chk("pkt2_level", bus.o_level, 2);
        chk("pkt2_cnt", bus.o_pkt_cnt, 1);
        chk("pkt2_head", bus.o_rd_data, 8'h56);
        chk("pkt2_head_last", bus.o_rd_last, 0);
        bus.i_rd_en = 1'b1;
        step();
        chk("pkt2_second", bus.o_rd_data, 8'h89);
        chk("pkt2_second_last", bus.o_rd_last, 1);
        step();
        bus.i_rd_en = 1'b0;
        chk("pkt2_empty", bus.o_rd_valid, 0);

        // overflow: fifth beat waits for a pop, then one extra cycle
        for (int i = 1; i <= 4; i++) send(DATA_W'(i), 1'b0);
        chk("full_level", bus.o_level, 4);
        chk("full_tready", bus.o_tready, 0);
        bus.i_tdata  = 8'h05;
        bus.i_tlast  = 1'b1;
        bus.i_tvalid = 1'b1;
        step();
        step();
        chk("full_hold_level", bus.o_level, 4);
        bus.i_rd_en = 1'b1;
        step();
        bus.i_rd_en = 1'b0;
        chk("pop_full_level", bus.o_level, 3);
        chk("pop_full_tready", bus.o_tready, 1);
        step();
        bus.i_tvalid = 1'b0;
        chk("refill_level", bus.o_level, 4);
        drain();

        // simultaneous push/pop at level 2
        send(8'hA1, 1'b1);
        send(8'hA2, 1'b1);
        chk("sim_level_before", bus.o_level, 2);
        bus.i_rd_en = 1'b1;
        send(8'hA3, 1'b1);
        bus.i_rd_en = 1'b0;
        chk("sim_level_after", bus.o_level, 2);
        drain();

        // packet FSM
        send(8'h10, 1'b0);
        chk("fsm_beat1", bus.o_in_pkt, 1);
        send(8'h11, 1'b0);
        chk("fsm_beat2", bus.o_in_pkt, 1);
        send(8'h12, 1'b1);
        chk("fsm_beat3", bus.o_in_pkt, 0);
        send(8'h13, 1'b1);
        chk("fsm_single", bus.o_in_pkt, 0);
        drain();

        // async reset mid-packet with three entries queued
        send(8'h21, 1'b0);
        send(8'h22, 1'b0);
        send(8'h23, 1'b0);
        chk("pre_rst_level", bus.o_level, 3);
        chk("pre_rst_in_pkt", bus.o_in_pkt, 1);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("rel_tready_pre", bus.o_tready, 0);
        step();
        chk("rel_tready_post", bus.o_tready, 1);

        // 256 single-beat packets with continuous pops wraps the counter
        bus.i_rd_en = 1'b1;
        for (int i = 0; i < 256; i++) send(DATA_W'(i), 1'b1);
        chk("wrap_pkt_cnt", bus.o_pkt_cnt, 0);
        for (int k = 0; k < 4; k++) step();
        chk("empty_pop_level", bus.o_level, 0);
        chk("empty_pop_valid", bus.o_rd_valid, 0);
        bus.i_rd_en = 1'b0;
        send(8'hA5, 1'b1);
        chk("after_empty_pop", bus.o_rd_data, 8'hA5);
        drain();

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            bus.i_tvalid = ($urandom_range(0, 3) != 0);
            bus.i_tdata  = DATA_W'($urandom);
            bus.i_tlast  = ($urandom_range(0, 3) == 0);
            bus.i_rd_en  = ($urandom_range(0, 2) != 0);
            step();
        end
        bus.i_tvalid = 1'b0;
        drain();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axis_stream_sink.md
AXIS_STREAM_SINK -- requirements
Module: axis_stream_sink

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named i_clk and i_rst.
REQ-002 Parameter DATA_W, default 8, SHALL set the tdata / read-data width.
REQ-003 Parameter DEPTH, default 4, power of two >= 2, SHALL set the FIFO entry count.
REQ-004 i_clk  in  1  rising-edge clock.
REQ-005 i_rst  in  1  asynchronous reset, active-low.
REQ-006 i_tdata  in  DATA_W  AXI4-Stream slave data.
REQ-007 i_tvalid  in  1  AXI4-Stream slave valid.
REQ-008 i_tlast  in  1  AXI4-Stream slave packet end.
REQ-009 o_tready  out  1  AXI4-Stream slave ready.
REQ-010 o_rd_data  out  DATA_W  head-of-FIFO data (show-ahead).
REQ-011 o_rd_last  out  1  head-of-FIFO tlast.
REQ-012 o_rd_valid  out  1  FIFO non-empty.
REQ-013 i_rd_en  in  1  consumer pop request.
REQ-014 o_level  out  $clog2(DEPTH)+1  current occupancy.
REQ-015 o_pkt_cnt  out  8  count of accepted tlast beats.
REQ-016 o_in_pkt  out  1  high while a multi-beat packet is partially accepted.

Function
REQ-017 A beat SHALL be accepted on a rising edge where i_tvalid=1 and o_tready=1; no other condition SHALL write the FIFO.
REQ-018 An accepted beat SHALL store {i_tlast, i_tdata} at the write pointer; the write pointer SHALL advance modulo DEPTH.
REQ-019 o_tready SHALL be a register updated every edge to (next o_level != DEPTH).
REQ-020 o_rd_valid SHALL equal (o_level != 0); o_rd_data/o_rd_last SHALL show the entry at the read pointer with no read latency.
REQ-021 A pop SHALL occur on an edge where i_rd_en=1 and o_rd_valid=1; the read pointer SHALL advance modulo DEPTH; i_rd_en while empty SHALL be ignored.
REQ-022 Latency: a beat accepted at edge N SHALL appear on o_rd_valid/o_rd_data after edge N when the FIFO was empty.
REQ-023 Simultaneous accept and pop SHALL leave o_level unchanged and preserve FIFO order.
REQ-024 When full, o_tready SHALL be 0, so a same-cycle pop SHALL NOT permit a same-cycle accept; o_tready SHALL return to 1 after the edge of the pop.
REQ-025 o_level SHALL be +1 on accept only, -1 on pop only, unchanged otherwise; it SHALL never exceed DEPTH or underflow.
REQ-026 o_pkt_cnt SHALL increment on each accepted beat with i_tlast=1 and wrap 255->0.
REQ-027 Packet FSM states: IDLE, IN_PKT; IDLE->IN_PKT on an accepted beat with tlast=0; IN_PKT->IDLE on an accepted beat with tlast=1; otherwise hold; a single-beat packet SHALL keep IDLE.
REQ-028 o_in_pkt SHALL be 1 exactly in IN_PKT.
REQ-029 Input changes while not accepted SHALL have no effect on any state.

Reset
REQ-030 While i_rst=0, pointers, o_level, o_pkt_cnt, and FIFO contents SHALL be 0, and FSM state SHALL be IDLE, independently of i_clk.
REQ-031 While i_rst=0, o_tready, o_rd_valid, o_rd_data, o_rd_last, and o_in_pkt SHALL be 0.
REQ-032 o_tready SHALL rise at the first edge after i_rst deasserts.
REQ-033 Reset asserted mid-packet or with a non-empty FIFO SHALL discard all contents and packet state.

Verification
REQ-034 Two-beat packet 0x56, then 0x89 with tlast, i_rd_en=0 -> o_level=2, o_pkt_cnt=1, o_rd_data=0x56, o_rd_last=0; two pops return 0x56, then 0x89 with o_rd_last=1; then o_rd_valid=0.
REQ-035 Overflow, DEPTH=4: 5 beats 0x01..0x05 with i_tvalid held and i_rd_en=0 -> 4 accepted, o_tready=0, o_level=4; one pop -> o_tready=1 next cycle, 0x05 accepted, read order 0x01..0x05.
REQ-036 Simultaneous push/pop: at o_level=2, accept a beat while popping -> o_level stays 2; data order is intact.
REQ-037 FSM: beats tlast=0,0,1 -> o_in_pkt is 1 after the first beat and 0 after the third; a single tlast=1 beat -> o_in_pkt stays 0.
REQ-038 Async reset: at o_level=3 in IN_PKT, drive i_rst=0 between clock edges -> all outputs 0 immediately, o_pkt_cnt=0; after release, o_tready=1 one edge later.
REQ-039 Wrap and empty pop: 256 single-beat packets with continuous pops -> o_pkt_cnt=0; i_rd_en=1 while empty -> no pointer/level change.
